// File: rtl/dotproduct_acc.sv
// -----------------------------------------------------------------------------
// dotproduct_acc
//
// Pipelined dot-product engine. Each beat multiplies N lane pairs and reduces
// them through a registered binary adder tree. Consecutive beats are
// accumulated until a LAST beat closes the vector, and the result is emitted
// with the destination tag carried on that LAST beat. The block takes one beat
// per cycle and has no backpressure. All arithmetic wraps modulo 2^DATA_W.
//
// Pipeline: M (products) -> T1..T(log2 N) (adder tree) -> C (accumulator).
// Total depth is log2(N)+2 registers. A LAST beat sampled at edge k raises
// VALID_O after edge k+log2(N)+1.
//
// Ports
//   ACLK         in   clock, rising edge
//   ARESETN      in   synchronous active-low reset
//   VALID_I      in   beat present on A_I/B_I/LAST_I/DEST_I
//   LAST_I       in   final beat of the current vector
//   DEST_I       in   destination tag, used only on the LAST beat
//   A_I, B_I     in   N lanes, lane k at [k*DATA_W +: DATA_W]
//   VALID_O      out  one-cycle pulse, DOT_PRODUCT/DEST_O hold a result
//   DOT_PRODUCT  out  accumulated dot product
//   DEST_O       out  tag of the completed vector
// -----------------------------------------------------------------------------
module dotproduct_acc #(
  parameter int DATA_W = 32,
  parameter int N      = 8,   // power of two, 2..64
  parameter int DEST_W = 6
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                VALID_I,
  input  logic                LAST_I,
  input  logic [DEST_W-1:0]   DEST_I,
  input  logic [N*DATA_W-1:0] A_I,
  input  logic [N*DATA_W-1:0] B_I,
  output logic                VALID_O,
  output logic [DATA_W-1:0]   DOT_PRODUCT,
  output logic [DEST_W-1:0]   DEST_O
);

  localparam int LOG2N = $clog2(N);
  // Every tree level is stored in one flat node array: level 0 (products)
  // occupies [0, N), level 1 the next N/2 entries, and so on down to the root.
  localparam int NODES = 2 * N - 1;
  localparam int ROOT  = 2 * N - 2;

  // First node index of tree level s.
  function automatic int lvl_off(input int s);
    return 2 * N - ((2 * N) >> s);
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath stages M and T1..T(log2 N)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] node_q [NODES];
  logic [LOG2N:0]    vld_q;                // vld_q[0] = stage M, vld_q[LOG2N] = tree root
  logic [LOG2N:0]    last_q;
  logic [DEST_W-1:0] dest_q [LOG2N+1];

  // NOTE: the products, tree nodes, last and dest carry no reset. Nothing
  // downstream looks at them unless the matching valid bit is set, and valids
  // do reset, so clearing this wide storage would buy nothing.
  always_ff @(posedge ACLK) begin
    // Products keep only the low DATA_W bits, so operand signedness is moot.
    for (int k = 0; k < N; k++) begin
      node_q[k] <= A_I[k*DATA_W +: DATA_W] * B_I[k*DATA_W +: DATA_W];
    end
    // Each tree level sums adjacent pairs (2j, 2j+1) of the level above.
    for (int s = 1; s <= LOG2N; s++) begin
      for (int j = 0; j < (N >> s); j++) begin
        node_q[lvl_off(s) + j] <= node_q[lvl_off(s-1) + 2*j]
                                + node_q[lvl_off(s-1) + 2*j + 1];
      end
    end
    last_q[0] <= LAST_I;
    dest_q[0] <= DEST_I;
    for (int s = 1; s <= LOG2N; s++) begin
      last_q[s] <= last_q[s-1];
      dest_q[s] <= dest_q[s-1];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values present before the edge, independent of the
  // order in which the statements are written.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LOG2N-1:0], VALID_I};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage C: accumulate beats until LAST, then publish the result
  // ---------------------------------------------------------------------------
  logic                tree_vld;
  logic                tree_last;
  logic [DEST_W-1:0]   tree_dest;
  logic [DATA_W-1:0]   tree_sum;

  assign tree_vld  = vld_q[LOG2N];
  assign tree_last = last_q[LOG2N];
  assign tree_dest = dest_q[LOG2N];
  assign tree_sum  = node_q[ROOT];

  logic [DATA_W-1:0] acc_q,   acc_d;
  logic              first_q, first_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dot_q,   dot_d;
  logic [DEST_W-1:0] dst_q,   dst_d;
  logic [DATA_W-1:0] acc_sum;

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    valid_d = 1'b0;
    dot_d   = dot_q;
    dst_d   = dst_q;
    // The first beat of a vector ignores whatever acc still holds, so a new
    // vector can follow a LAST beat with no gap and no leakage.
    acc_sum = (first_q ? '0 : acc_q) + tree_sum;
    if (tree_vld) begin
      if (tree_last) begin
        dot_d   = acc_sum;
        dst_d   = tree_dest;
        valid_d = 1'b1;
        first_d = 1'b1;
      end else begin
        acc_d   = acc_sum;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      acc_q   <= '0;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      dot_q   <= '0;
      dst_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      first_q <= first_d;
      valid_q <= valid_d;
      dot_q   <= dot_d;
      dst_q   <= dst_d;
    end
  end

  assign VALID_O     = valid_q;
  assign DOT_PRODUCT = dot_q;
  assign DEST_O      = dst_q;

endmodule

// File: tb/tb_dotproduct_acc.sv
// -----------------------------------------------------------------------------
// tb_dotproduct_acc
//
// Directed scenarios followed by random beats. A reference model computes each
// beat's dot product with plain arithmetic, accumulates beats per vector, and
// queues every finished vector with the edge at which its result is due. Every
// clock edge compares VALID_O, DOT_PRODUCT and DEST_O with the model; the
// directed scenarios also compare captured results with fixed constants.
// -----------------------------------------------------------------------------
module tb_dotproduct_acc;

  localparam int DATA_W = 32;
  localparam int N      = 8;
  localparam int DEST_W = 6;
  localparam int L      = $clog2(N) + 2;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic                VALID_I;
  logic                LAST_I;
  logic [DEST_W-1:0]   DEST_I;
  logic [N*DATA_W-1:0] A_I;
  logic [N*DATA_W-1:0] B_I;
  logic                VALID_O;
  logic [DATA_W-1:0]   DOT_PRODUCT;
  logic [DEST_W-1:0]   DEST_O;

  dotproduct_acc #(.DATA_W(DATA_W), .N(N), .DEST_W(DEST_W)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .VALID_I     (VALID_I),
    .LAST_I      (LAST_I),
    .DEST_I      (DEST_I),
    .A_I         (A_I),
    .B_I         (B_I),
    .VALID_O     (VALID_O),
    .DOT_PRODUCT (DOT_PRODUCT),
    .DEST_O      (DEST_O)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] val;
    logic [DEST_W-1:0] dest;
  } exp_t;

  exp_t              pend[$];
  logic [DATA_W-1:0] m_acc;
  logic [DATA_W-1:0] exp_dot;
  logic [DEST_W-1:0] exp_dest;
  int                edge_cnt;
  int                checks;
  int                errors;
  int                pulses;
  logic [DATA_W-1:0] cap_dot[$];
  logic [DEST_W-1:0] cap_dest[$];
  int                cap_edge[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_cnt, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] beat_sum(input logic [N*DATA_W-1:0] a,
                                                 input logic [N*DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s += a[k*DATA_W +: DATA_W] * b[k*DATA_W +: DATA_W];
    return s;
  endfunction

  // One clock edge: the model absorbs what the DUT sampled, then outputs are
  // compared 1 time unit after the edge.
  task automatic tick();
    logic exp_v;
    exp_t e;
    @(posedge ACLK);
    edge_cnt++;
    if (!ARESETN) begin
      pend.delete();
      m_acc    = '0;
      exp_dot  = '0;
      exp_dest = '0;
    end else if (VALID_I) begin
      m_acc += beat_sum(A_I, B_I);
      if (LAST_I) begin
        pend.push_back('{edge_cnt + L - 1, m_acc, DEST_I});
        m_acc = '0;
      end
    end
    #1;
    exp_v = (pend.size() > 0) && (pend[0].due == edge_cnt);
    if (exp_v) begin
      e        = pend.pop_front();
      exp_dot  = e.val;
      exp_dest = e.dest;
    end
    check("valid_o", 64'(VALID_O), 64'(exp_v));
    check("dot_product", 64'(DOT_PRODUCT), 64'(exp_dot));
    check("dest_o", 64'(DEST_O), 64'(exp_dest));
    if (VALID_O === 1'b1) begin
      pulses++;
      cap_dot.push_back(DOT_PRODUCT);
      cap_dest.push_back(DEST_O);
      cap_edge.push_back(edge_cnt);
    end
  endtask

  task automatic beat(input logic last, input logic [DEST_W-1:0] dest,
                      input logic [N*DATA_W-1:0] a, input logic [N*DATA_W-1:0] b);
    VALID_I = 1'b1;
    LAST_I  = last;
    DEST_I  = dest;
    A_I     = a;
    B_I     = b;
    tick();
  endtask

  // Idle cycles carry junk, including LAST_I=1, which must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      VALID_I = 1'b0;
      LAST_I  = 1'b1;
      DEST_I  = DEST_W'($urandom);
      for (int k = 0; k < N; k++) begin
        A_I[k*DATA_W +: DATA_W] = $urandom;
        B_I[k*DATA_W +: DATA_W] = $urandom;
      end
      tick();
    end
  endtask

  task automatic clear_caps();
    pulses = 0;
    cap_dot.delete();
    cap_dest.delete();
    cap_edge.delete();
  endtask

  function automatic logic [N*DATA_W-1:0] splat(input logic [DATA_W-1:0] v);
    logic [N*DATA_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  function automatic logic [N*DATA_W-1:0] lane0(input logic [DATA_W-1:0] v);
    logic [N*DATA_W-1:0] r;
    r = '0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  initial begin
    logic [N*DATA_W-1:0] ramp;
    logic [N*DATA_W-1:0] ra;
    logic [N*DATA_W-1:0] rb;
    int                  k0;

    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    m_acc    = '0;
    exp_dot  = '0;
    exp_dest = '0;
    clear_caps();
    for (int k = 0; k < N; k++) ramp[k*DATA_W +: DATA_W] = DATA_W'(k + 1);

    // Reset: outputs must read zero.
    ARESETN = 1'b0;
    idle(3);
    ARESETN = 1'b1;
    idle(2);

    // Single beat, A=1..8, B=1: result 36 four edges after the LAST beat.
    clear_caps();
    beat(1'b1, 6'h15, ramp, splat(1));
    k0 = edge_cnt;
    idle(6);
    check("single_pulses", 64'(pulses), 64'd1);
    check("single_dot", 64'(cap_dot[0]), 64'd36);
    check("single_dest", 64'(cap_dest[0]), 64'h15);
    check("single_latency", 64'(cap_edge[0]), 64'(k0 + 4));

    // Three beats, A=1, B=2, LAST on the third.
    clear_caps();
    beat(1'b0, 6'h01, splat(1), splat(2));
    beat(1'b0, 6'h02, splat(1), splat(2));
    beat(1'b1, 6'h3F, splat(1), splat(2));
    idle(6);
    check("three_pulses", 64'(pulses), 64'd1);
    check("three_dot", 64'(cap_dot[0]), 64'd48);
    check("three_dest", 64'(cap_dest[0]), 64'h3F);

    // Same three beats with idle gaps of 2 and 5.
    clear_caps();
    beat(1'b0, 6'h0A, splat(1), splat(2));
    idle(2);
    beat(1'b0, 6'h0B, splat(1), splat(2));
    idle(5);
    beat(1'b1, 6'h3F, splat(1), splat(2));
    k0 = edge_cnt;
    idle(6);
    check("gap_pulses", 64'(pulses), 64'd1);
    check("gap_dot", 64'(cap_dot[0]), 64'd48);
    check("gap_latency", 64'(cap_edge[0]), 64'(k0 + 4));

    // Wrap-around: all-ones operands give 8; two beats summing to 2^32+5 give 5.
    clear_caps();
    beat(1'b1, 6'h07, splat('1), splat('1));
    beat(1'b0, 6'h00, lane0(32'hFFFF_FFFF), lane0(1));
    beat(1'b1, 6'h08, lane0(6), lane0(1));
    idle(6);
    check("wrap_pulses", 64'(pulses), 64'd2);
    check("wrap_ones", 64'(cap_dot[0]), 64'd8);
    check("wrap_two_beat", 64'(cap_dot[1]), 64'd5);

    // Back-to-back single-beat vectors: results 1..4, tags 0..3.
    clear_caps();
    for (int i = 0; i < 4; i++) beat(1'b1, DEST_W'(i), lane0(DATA_W'(i + 1)), lane0(1));
    idle(6);
    check("b2b_pulses", 64'(pulses), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("b2b_dot", 64'(cap_dot[i]), 64'(i + 1));
      check("b2b_dest", 64'(cap_dest[i]), 64'(i));
      check("b2b_consecutive", 64'(cap_edge[i]), 64'(cap_edge[0] + i));
    end

    // Reset mid-vector: the aborted vector must produce nothing.
    clear_caps();
    beat(1'b0, 6'h11, splat(5), splat(5));
    beat(1'b0, 6'h12, splat(5), splat(5));
    ARESETN = 1'b0;
    beat(1'b1, 6'h13, splat(3), splat(3));
    check("rst_dot_zero", 64'(DOT_PRODUCT), 64'd0);
    check("rst_dest_zero", 64'(DEST_O), 64'd0);
    ARESETN = 1'b1;
    beat(1'b1, 6'h2A, ramp, splat(1));
    idle(8);
    check("rst_pulses", 64'(pulses), 64'd1);
    check("rst_dot", 64'(cap_dot[0]), 64'd36);
    check("rst_dest", 64'(cap_dest[0]), 64'h2A);

    // Random beats with sparse valids, random LAST and an occasional reset.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        ra[k*DATA_W +: DATA_W] = $urandom;
        rb[k*DATA_W +: DATA_W] = $urandom;
      end
      ARESETN = ($urandom_range(0, 79) != 0);
      VALID_I = ($urandom_range(0, 3) != 0);
      LAST_I  = ($urandom_range(0, 2) == 0);
      DEST_I  = DEST_W'($urandom);
      A_I     = ra;
      B_I     = rb;
      tick();
    end
    ARESETN = 1'b1;
    idle(8);
    check("drain_empty", 64'(pend.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dotproduct_acc.md
# dotproduct_acc

Parametrised pipelined dot-product engine for the matrix-multiply datapath. It multiplies N element pairs per beat, reduces them through a registered binary adder tree, and can accumulate several beats into one result, so rows longer than N elements need no software post-add. A destination tag travels with each vector so the writeback stage knows where to store the result. The block accepts one beat per cycle and has no backpressure.

## Interface
- DATA_W, 32, element, product and sum width in bits
- N, 8, lanes per beat; power of two, 2..64
- DEST_W, 6, destination tag width
- ACLK  in  1  clock; all state updates on rising edge
- ARESETN  in  1  reset, synchronous, active-low
- VALID_I  in  1  beat present on A_I/B_I/DEST_I/LAST_I this cycle
- LAST_I  in  1  final beat of the current vector
- DEST_I  in  DEST_W  destination tag; only the value on the LAST_I beat is used
- A_I  in  N*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- B_I  in  N*DATA_W  same packing as A_I
- VALID_O  out  1  one-cycle pulse: DOT_PRODUCT/DEST_O hold a completed vector
- DOT_PRODUCT  out  DATA_W  accumulated dot product
- DEST_O  out  DEST_W  tag of the completed vector

## Operation
- Stage M (1 register): prod[k] = A_I[k]*B_I[k], truncated to the low DATA_W bits. Arithmetic is modulo 2^DATA_W, so signed and unsigned operands give the same result.
- Stages T1..T(log2 N): each stage registers pairwise sums of the previous stage (modulo 2^DATA_W). Lane pairs are (2j, 2j+1).
- Each pipeline stage carries valid, last and dest alongside its data.
- Stage C (accumulator) runs only when the tree output valid is set. Let sum = (first ? 0 : acc) + tree.
  - If last=1: DOT_PRODUCT<=sum, DEST_O<=dest, VALID_O<=1, first<=1.
  - If last=0: acc<=sum, first<=0, VALID_O<=0.
- When the tree output valid is 0: acc and first hold, VALID_O<=0, DOT_PRODUCT and DEST_O hold.
- Idle cycles (VALID_I=0) between beats of one vector do not affect the result.
- A vector is any run of valid beats ending in a LAST_I beat. A LAST_I beat with no earlier beats is a single-beat vector.
- VALID_I=0 ignores every other input, including LAST_I.
- There is no overflow flag; wrap-around is silent.

## Timing
- Total pipeline depth is L = log2(N)+2 register stages (N=8 gives L=5).
- A LAST beat sampled at rising edge k produces VALID_O=1 after edge k+L-1, held for exactly one cycle. For N=8 that is edge k+4.
- Throughput is one beat per cycle. Back-to-back single-beat vectors give VALID_O on consecutive cycles with independent results.
- A vector boundary needs no gap: the beat after a LAST beat starts a new vector via the first flag, with no leakage from the previous acc.
- Reset (ARESETN=0 at an edge):
  - VALID_O=0, DOT_PRODUCT=0, DEST_O=0.
  - All pipeline valid bits 0, acc=0, first=1.
  - Data registers may also clear to 0.
- Reset mid-vector discards all in-flight beats and the partial acc. No VALID_O is produced for them, and the first beat after reset release starts a new vector.
- There is no combinational path from any input to any output.

## Test plan
- Single beat, N=8: A=1..8, B=all 1, LAST=1, DEST=0x15 at edge k. Expect VALID_O only after edge k+4, DOT_PRODUCT=36 (0x24), DEST_O=0x15.
- Three beats: A=all 1, B=all 2 on each beat, LAST only on the third, DEST=0x3F on the third. Expect exactly one VALID_O pulse with DOT_PRODUCT=48 and DEST_O=0x3F.
- Same three beats with 2 idle cycles after beat 1 and 5 after beat 2. Expect result 48, with the pulse 4 edges after the LAST beat.
- Wrap-around: all A=B=0xFFFFFFFF, single beat. Expect DOT_PRODUCT=8. Also a two-beat vector with sum reaching 2^32+5 returns 5.
- Back-to-back single-beat vectors on 4 consecutive cycles with results 1, 2, 3, 4 and tags 0..3. Expect 4 consecutive VALID_O cycles with matching results and tags in order, and no carry between vectors.
- Reset mid-vector: 2 non-last beats, then ARESETN=0 for 1 cycle, then a single-beat vector giving 36. Expect no pulse for the aborted vector, outputs 0 during reset, then exactly one pulse with 36.
